// File: rtl/common.sv
// Constants and address helpers shared by the Jacobi engine blocks.
package common;

  localparam int unsigned JACOBI_N                 = 8;
  localparam int unsigned JACOBI_OUTPUT_WORD_WIDTH = 16;
  localparam int unsigned JACOBI_ADDR_WIDTH        = 7;
  localparam int unsigned JACOBI_V_OFFSET          = 64;
  localparam int unsigned JACOBI_N_OUTPUT_DATA     = JACOBI_N + JACOBI_N * JACOBI_N;

  // W is stored row-major with an 8-word row pitch starting at address 0.
  function automatic int unsigned jacobi_addr_gen_lut(input int unsigned n,
                                                      input int unsigned k);
    return (n << 3) + k;
  endfunction

endpackage

// File: rtl/jacobi_stream_fifo.sv
// Two-entry synchronous FIFO with occupancy count; head is visible on o_data.
module jacobi_stream_fifo #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic [1:0]       o_count
);

  logic [Width-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (i_push) r_wptr <= ~r_wptr;
      if (i_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/jacobi_result_streamer.sv
// Streams the eigenvalues (diag of W) then V from RAM port B over valid/ready/last.
module jacobi_result_streamer
  import common::*;
#(
  parameter int unsigned N        = JACOBI_N,
  parameter int unsigned WORD_W   = JACOBI_OUTPUT_WORD_WIDTH,
  parameter int unsigned ADDR_W   = JACOBI_ADDR_WIDTH,
  parameter int unsigned V_OFFSET = JACOBI_V_OFFSET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ram_en_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  input  logic [WORD_W-1:0] ram_dout_i,
  output logic [31:0]       out_dat_o,
  output logic              out_vld_o,
  output logic              out_last_o,
  input  logic              out_rdy_i
);

  typedef enum logic [1:0] {IDLE, DIAG, VMAT, DRAIN} stream_fsm_t;

  localparam int unsigned     IdxW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  stream_fsm_t       r_state, w_state_d;
  logic [IdxW-1:0]   r_row, w_row_d;
  logic [IdxW-1:0]   r_col, w_col_d;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_d;
  logic              r_inflight, r_inflight_last;
  logic              r_done, w_done_d;
  logic              w_issue, w_issue_last;
  logic              w_pop, w_credit;
  logic [1:0]        w_fifo_count;
  logic [2:0]        w_occ;
  logic [WORD_W:0]   w_fifo_head;

  function automatic logic [ADDR_W-1:0] diag_addr(input logic [IdxW-1:0] i);
    return ADDR_W'(jacobi_addr_gen_lut(32'(i), 32'(i)));
  endfunction

  function automatic logic [ADDR_W-1:0] v_addr(input logic [IdxW-1:0] r,
                                               input logic [IdxW-1:0] c);
    return ADDR_W'(V_OFFSET + (32'(r) << 3) + 32'(c));
  endfunction

  assign out_vld_o = (w_fifo_count != 2'd0);
  assign w_pop     = out_vld_o & out_rdy_i;

  // Occupancy after this cycle's pop, plus the word coming back from RAM.
  // Counting the pop lets a freed slot be refilled in the same cycle.
  assign w_occ    = {1'b0, w_fifo_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_credit = (w_occ < 3'd2);

  always_comb begin
    w_state_d    = r_state;
    w_row_d      = r_row;
    w_col_d      = r_col;
    w_ram_addr_d = r_ram_addr;
    w_done_d     = 1'b0;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_d    = DIAG;
          w_row_d      = '0;
          w_col_d      = '0;
          w_ram_addr_d = diag_addr('0);
        end
      end
      DIAG: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_row == LastIdx) begin
            w_state_d    = VMAT;
            w_row_d      = '0;
            w_ram_addr_d = v_addr('0, '0);
          end else begin
            w_row_d      = r_row + 1'b1;
            w_ram_addr_d = diag_addr(r_row + 1'b1);
          end
        end
      end
      VMAT: begin
        if (w_credit) begin
          w_issue = 1'b1;
          if (r_col == LastIdx) begin
            w_col_d = '0;
            if (r_row == LastIdx) begin
              w_state_d    = DRAIN;
              w_issue_last = 1'b1;
            end else begin
              w_row_d      = r_row + 1'b1;
              w_ram_addr_d = v_addr(r_row + 1'b1, '0);
            end
          end else begin
            w_col_d      = r_col + 1'b1;
            w_ram_addr_d = v_addr(r_row, r_col + 1'b1);
          end
        end
      end
      DRAIN: begin
        if (w_pop && w_fifo_head[WORD_W]) begin
          w_state_d = IDLE;
          w_done_d  = 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_row           <= '0;
      r_col           <= '0;
      r_ram_addr      <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_row           <= w_row_d;
      r_col           <= w_col_d;
      r_ram_addr      <= w_ram_addr_d;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
      r_done          <= w_done_d;
    end
  end

  // The last flag travels with its data word so out_last_o needs no counter.
  jacobi_stream_fifo #(
    .Width (WORD_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, ram_dout_i}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_count (w_fifo_count)
  );

  assign ram_en_o   = w_issue;
  assign ram_addr_o = r_ram_addr;
  assign busy_o     = (r_state != IDLE);
  assign done_o     = r_done;
  assign out_last_o = out_vld_o & w_fifo_head[WORD_W];
  assign out_dat_o  = out_vld_o ? 32'($signed(w_fifo_head[WORD_W-1:0])) : 32'd0;

endmodule

// File: tb/tb_jacobi_result_streamer.sv
// Directed bench for jacobi_result_streamer against a RAM model and an expected word list.
module tb_jacobi_result_streamer;
  import common::*;

  localparam int unsigned N      = JACOBI_N;
  localparam int unsigned WW     = JACOBI_OUTPUT_WORD_WIDTH;
  localparam int unsigned AW     = JACOBI_ADDR_WIDTH;
  localparam int          NW     = JACOBI_N_OUTPUT_DATA;
  localparam int          MaxCyc = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          busy_o, done_o, ram_en_o;
  logic [AW-1:0] ram_addr_o;
  logic [WW-1:0] ram_dout_i;
  logic [31:0]   out_dat_o;
  logic          out_vld_o, out_last_o, out_rdy_i;

  logic [WW-1:0] mem [2**AW];
  logic [31:0]   got [NW];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int c0    = 0;
  bit mon_en = 1'b0;
  int mon_idx, reads, stall_reads, done_rel, last_hs, last_idx;
  bit done_seen, prev_stall, prev_last, st_vld;
  logic [31:0] prev_dat, st_dat;

  jacobi_result_streamer #(
    .N        (JACOBI_N),
    .WORD_W   (JACOBI_OUTPUT_WORD_WIDTH),
    .ADDR_W   (JACOBI_ADDR_WIDTH),
    .V_OFFSET (JACOBI_V_OFFSET)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ram_en_o   (ram_en_o),
    .ram_addr_o (ram_addr_o),
    .ram_dout_i (ram_dout_i),
    .out_dat_o  (out_dat_o),
    .out_vld_o  (out_vld_o),
    .out_last_o (out_last_o),
    .out_rdy_i  (out_rdy_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM port B.
  always @(posedge clk) if (ram_en_o) ram_dout_i <= mem[ram_addr_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word k of the stream: eigenvalues W[k][k], then V row-major.
  function automatic logic [31:0] exp_word(input int k);
    logic [WW-1:0] w;
    int r, c;
    if (k < int'(N)) begin
      w = mem[AW'(k * 8 + k)];
    end else begin
      r = (k - int'(N)) / int'(N);
      c = (k - int'(N)) % int'(N);
      w = mem[AW'(int'(JACOBI_V_OFFSET) + r * 8 + c)];
    end
    return 32'($signed(w));
  endfunction

  task automatic load(input bit neg);
    for (int a = 0; a < 64; a++) mem[a] = WW'(256 + a);
    for (int i = 0; i < int'(N); i++) mem[i * 9] = WW'(10 + i);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mem[64 + r * 8 + c] = (r == c) ? WW'(1) : WW'(0);
    if (neg) mem[0] = WW'(-5);
  endtask

  function automatic logic rdy_for(input int mode, input int t);
    if (mode == 1) return logic'($urandom_range(0, 1));
    if (mode == 2) return (t > 20);
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    int rel;
    if (mon_en) begin
      rel = cyc - c0;
      if (ram_en_o) reads++;
      if (rel == 1) begin
        chk("busy_cycle1", 32'(busy_o), 32'd1);
        chk("ren_cycle1", 32'(ram_en_o), 32'd1);
        chk("raddr_cycle1", 32'(ram_addr_o), 32'd0);
      end
      if (rel == 20) begin
        stall_reads = reads;
        st_vld      = out_vld_o;
        st_dat      = out_dat_o;
      end
      if (prev_stall) begin
        chk("hold_vld", 32'(out_vld_o), 32'd1);
        chk("hold_dat", out_dat_o, prev_dat);
        chk("hold_last", 32'(out_last_o), 32'(prev_last));
      end
      if (out_vld_o) begin
        if (mon_idx >= NW) begin
          chk("extra_word", 32'(mon_idx), 32'(NW - 1));
        end else begin
          chk("data", out_dat_o, exp_word(mon_idx));
          chk("last", 32'(out_last_o), 32'(mon_idx == NW - 1));
          if (out_rdy_i) begin
            got[mon_idx] = out_dat_o;
            if (out_last_o) last_idx = mon_idx;
            if (mon_idx == NW - 1) last_hs = rel;
          end
        end
        if (out_rdy_i) mon_idx++;
      end
      prev_stall = out_vld_o && !out_rdy_i;
      prev_dat   = out_dat_o;
      prev_last  = out_last_o;
      if (done_o && !done_seen) begin
        done_seen = 1'b1;
        done_rel  = rel;
      end
    end
  end

  task automatic run(input int mode, input int extra_start, input int rst_at);
    mon_idx = 0; reads = 0; stall_reads = 0; done_seen = 1'b0; done_rel = -1;
    last_hs = -1; last_idx = -1; prev_stall = 1'b0; st_vld = 1'b0; st_dat = '0;
    for (int i = 0; i < NW; i++) got[i] = 32'hDEAD_BEEF;
    out_rdy_i = rdy_for(mode, 0);
    start_i   = 1'b1;
    c0        = cyc;
    mon_en    = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int t = 1; t < MaxCyc && !done_seen; t++) begin
      if (rst_at >= 0 && mon_idx >= rst_at) begin
        mon_en = 1'b0;
        rst    = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ren", 32'(ram_en_o), 32'd0);
        chk("rst_raddr", 32'(ram_addr_o), 32'd0);
        chk("rst_vld", 32'(out_vld_o), 32'd0);
        chk("rst_last", 32'(out_last_o), 32'd0);
        chk("rst_dat", out_dat_o, 32'd0);
        @(posedge clk); #1;
        return;
      end
      out_rdy_i = rdy_for(mode, t);
      start_i   = (t == extra_start);
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    mon_en  = 1'b0;
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
    else            chk("done_after_last", 32'(done_rel), 32'(last_hs + 1));
    chk("word_count", 32'(mon_idx), 32'(NW));
    chk("last_index", 32'(last_idx), 32'(NW - 1));
    chk("idle_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; out_rdy_i = 1'b0;
    load(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_ren", 32'(ram_en_o), 32'd0);
    chk("reset_raddr", 32'(ram_addr_o), 32'd0);
    chk("reset_vld", 32'(out_vld_o), 32'd0);
    chk("reset_last", 32'(out_last_o), 32'd0);
    chk("reset_dat", out_dat_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full-rate run with hand-computed anchors.
    run(0, -1, -1);
    chk("w00", got[0], 32'd10);
    chk("w77", got[7], 32'd17);
    chk("v00", got[8], 32'd1);
    chk("v01", got[9], 32'd0);
    chk("v11", got[17], 32'd1);
    chk("v10", got[16], 32'd0);
    chk("v77", got[71], 32'd1);
    chk("last_hs_cycle", 32'(last_hs), 32'd74);
    chk("done_cycle", 32'(done_rel), 32'd75);

    // Random back-pressure.
    run(1, -1, -1);

    // Ready held low for 20 cycles after start.
    run(2, -1, -1);
    chk("stall_reads_le2", 32'(stall_reads <= 2), 32'd1);
    chk("stall_vld", 32'(st_vld), 32'd1);
    chk("stall_dat", st_dat, 32'd10);

    // Second start mid-run is ignored.
    run(0, 30, -1);
    chk("restart_ignored_done", 32'(done_rel), 32'd75);

    // Reset at word 30, then a clean run.
    run(0, -1, 30);
    run(0, -1, -1);
    chk("after_rst_w00", got[0], 32'd10);
    chk("after_rst_done", 32'(done_rel), 32'd75);

    // Negative value sign extension.
    load(1'b1);
    run(0, -1, -1);
    chk("neg_w00", got[0], 32'hFFFF_FFFB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
